fir_filter_direct: RTL and testbench
====================================

FIR_FILTER_DIRECT -- requirements
Module: fir_filter_direct

Interface
REQ-001 Parameter: TRANSPOSED, default 0, 0 = direct-form datapath, 1 = transposed-form datapath; the port-level behaviour SHALL be identical for both values.
REQ-002 Port: iClk_12M  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: iRsn  input  1  reset, synchronous, active-high.
REQ-004 Port: iCoeffiUpdateFlag  input  1  coefficient-write enable qualifier.
REQ-005 Port: iCsnRam  input  1  coefficient store chip select, active low.
REQ-006 Port: iWrnRam  input  1  coefficient store write strobe, active low.
REQ-007 Port: iAddrRam  input  6  coefficient address; 1..33 SHALL map to taps h[0]..h[32].
REQ-008 Port: iWrDtRam  input  16  signed two's-complement coefficient write data.
REQ-009 Port: iFirIn  input  3  signed two's-complement input sample, range -4..+3.
REQ-010 Port: oFirOut  output  16  signed two's-complement registered filter output.

Function
REQ-011 The filter SHALL have 33 taps, h[0]..h[32], each a 16-bit signed register.
REQ-012 A coefficient write SHALL occur on a rising edge when iCoeffiUpdateFlag=1, iCsnRam=0, iWrnRam=0 and iAddrRam is in 1..33: h[iAddrRam-1] <= iWrDtRam.
REQ-013 Addresses 0 and 34..63 SHALL be ignored, with no state change.
REQ-014 Writes SHALL be ignored when any qualifier is inactive (flag=0, iCsnRam=1 or iWrnRam=1).
REQ-015 Read cycles (iCsnRam=0, iWrnRam=1) SHALL have no effect; no read data port exists.
REQ-016 The filter SHALL process one sample every clock; there is no sample enable.
REQ-017 iFirIn sampled at edge n is x[n].
REQ-018 oFirOut after edge n+1 SHALL equal sat16(sum over k=0..32 of h[k]*x[n-k]), using x[m]=0 for samples before reset release.
REQ-019 Latency from input to first contribution on oFirOut SHALL be exactly 1 clock.
REQ-020 Products SHALL be 19-bit signed (3b x 16b); accumulation SHALL be at least 25-bit signed, with no intermediate overflow.
REQ-021 sat16 SHALL clamp to +32767 / -32768; in-range values SHALL pass unchanged (no truncation of LSBs).
REQ-022 The filter SHALL keep running during coefficient writes.
REQ-023 A coefficient written at edge n SHALL be used in the output produced at edge n+1 and later.
REQ-024 Output already in flight SHALL NOT be corrected retroactively.
REQ-025 For TRANSPOSED=1, partial-sum registers SHALL be sized at least 25 bits, with saturation applied only at the output register.
REQ-026 For TRANSPOSED=1, after a coefficient change the output SHALL match the direct form cycle-for-cycle.
REQ-027 TRANSPOSED=1 SHALL reach that match by storing x-history, or by recomputation, as needed to keep REQ-026 exact.

Reset
REQ-028 While iRsn=1 at a rising edge, the following SHALL be cleared to 0: all delay-line / partial-sum registers, all 33 coefficients, and oFirOut.
REQ-029 Reset SHALL take priority over a simultaneous coefficient write.
REQ-030 Reset mid-stream SHALL discard sample history; output SHALL be 0 on the cycle after reset is released until new nonzero samples arrive.

Verification
REQ-031 Reset, then iFirIn=3 held for 50 clocks with no writes -> oFirOut=0 throughout (coefficients are zero).
REQ-032 Write 33 coefficients at addr 1..33: 3,0,-6,7,0,-11,13,0,-19,24,0,-37,48,0,-102,206,500,206,-102,0,48,-37,0,24,-19,0,13,-11,0,7,-6,0,3. Then apply a single-clock impulse iFirIn=1 -> oFirOut shows that sequence on 33 consecutive cycles starting 1 clock after the impulse edge, then 0.
REQ-033 Same coefficients, impulse iFirIn=-4 (3'b100) -> outputs are -4*h[k], e.g. peak -2000, first -12.
REQ-034 All coefficients 16'h7FFF, iFirIn=3 held -> output ramps 98301 per tap, clamps at +32767; iFirIn=-4 held -> clamps at -32768.
REQ-035 Write attempts with iCoeffiUpdateFlag=0, or iWrnRam=1, or addr 0/34 -> impulse response unchanged from the prior coefficient set.
REQ-036 Instantiate TRANSPOSED=0 and =1 side by side with identical stimulus, including a coefficient rewrite mid-stream -> oFirOut equal every cycle.

Source files
------------

// File: rtl/fir_filter_direct.sv
// -----------------------------------------------------------------------------
// fir_filter_direct
//   33-tap FIR filter with a 3-bit signed input sample and 16-bit signed
//   coefficients. The coefficients are held in registers and written through
//   a RAM-style strobe interface. One sample is processed every clock, and the
//   16-bit output is registered and saturated.
//
// Parameters
//   TRANSPOSED        0 = direct-form summation, 1 = transposed-order
//                     partial-sum chain. Port-level behaviour is identical.
//
// Ports
//   iClk_12M          single clock; all state updates on its rising edge
//   iRsn              synchronous reset, active high; clears history,
//                     coefficients and output
//   iCoeffiUpdateFlag coefficient-write enable qualifier
//   iCsnRam           coefficient store chip select, active low
//   iWrnRam           coefficient store write strobe, active low
//   iAddrRam          coefficient address; 1..33 selects h[0]..h[32]
//   iWrDtRam          signed coefficient write data
//   iFirIn            signed input sample, -4..+3
//   oFirOut           signed saturated filter output, registered
// -----------------------------------------------------------------------------
module fir_filter_direct #(
    parameter int TRANSPOSED = 0
) (
    input  logic               iClk_12M,
    input  logic               iRsn,
    input  logic               iCoeffiUpdateFlag,
    input  logic               iCsnRam,
    input  logic               iWrnRam,
    input  logic [5:0]         iAddrRam,
    input  logic signed [15:0] iWrDtRam,
    input  logic signed [2:0]  iFirIn,
    output logic signed [15:0] oFirOut
);

    localparam int unsigned TAPS   = 33;
    localparam int unsigned PROD_W = 19;
    // 33 * 4 * 32768 needs 24 bits signed. The extra headroom keeps the
    // accumulation free of overflow.
    localparam int unsigned ACC_W  = 26;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    logic signed [15:0]       coeff [TAPS];
    logic signed [2:0]        xHist [TAPS];
    logic signed [PROD_W-1:0] prod  [TAPS];
    logic signed [ACC_W-1:0]  sumNext;
    logic signed [15:0]       satNext;
    logic                     coeffWrEn;

    // Only a fully qualified write to addresses 1..33 changes a coefficient.
    always_comb begin
        coeffWrEn = iCoeffiUpdateFlag && !iCsnRam && !iWrnRam &&
                    (iAddrRam >= 6'd1) && (iAddrRam <= 6'd33);
    end

    // Coefficient registers. Reset has priority over a simultaneous write.
    always_ff @(posedge iClk_12M) begin
        if (iRsn) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                coeff[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                if (coeffWrEn && (iAddrRam == 6'(k + 1))) begin
                    coeff[k] <= iWrDtRam;
                end
            end
        end
    end

    // Sample history. xHist[k] holds x[n-k] after edge n.
    always_ff @(posedge iClk_12M) begin
        if (iRsn) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                xHist[k] <= '0;
            end
        end else begin
            xHist[0] <= iFirIn;
            for (int unsigned k = 1; k < TAPS; k++) begin
                xHist[k] <= xHist[k-1];
            end
        end
    end

    // 3b x 16b signed products.
    always_comb begin
        for (int unsigned k = 0; k < TAPS; k++) begin
            prod[k] = PROD_W'(xHist[k]) * PROD_W'(coeff[k]);
        end
    end

    generate
        if (TRANSPOSED == 0) begin : gDirect
            always_comb begin
                sumNext = '0;
                for (int unsigned k = 0; k < TAPS; k++) begin
                    sumNext = sumNext + ACC_W'(prod[k]);
                end
            end
        end else begin : gTransposed
            // The partial-sum chain runs from the oldest tap toward tap 0.
            // It is recomputed each cycle from the stored sample history
            // instead of being held in pipelined partial-sum registers. A
            // coefficient write therefore takes effect on the next output
            // exactly as in the direct form, with no stale partial products.
            logic signed [ACC_W-1:0] partialSum;
            always_comb begin
                partialSum = '0;
                for (int unsigned i = 0; i < TAPS; i++) begin
                    partialSum = partialSum + ACC_W'(prod[TAPS-1-i]);
                end
                sumNext = partialSum;
            end
        end
    endgenerate

    // Clamp to the 16-bit range. In-range values pass through unchanged.
    always_comb begin
        if (sumNext > SAT_MAX) begin
            satNext = 16'sh7FFF;
        end else if (sumNext < SAT_MIN) begin
            satNext = 16'sh8000;
        end else begin
            satNext = sumNext[15:0];
        end
    end

    always_ff @(posedge iClk_12M) begin
        if (iRsn) begin
            oFirOut <= '0;
        end else begin
            oFirOut <= satNext;
        end
    end

endmodule

// File: tb/tb_fir_filter_direct.sv
module tb_fir_filter_direct;

    logic               clk;
    logic               rst;
    logic               flag;
    logic               csn;
    logic               wrn;
    logic [5:0]         addr;
    logic signed [15:0] wdat;
    logic signed [2:0]  xin;
    logic signed [15:0] out0;
    logic signed [15:0] out1;

    int tests;
    int fails;

    // Reference state: the coefficient set and the sample history since the
    // last reset (newest sample first).
    int mH [33];
    int xq [$];
    int mOut;

    int coefTab [33] = '{3, 0, -6, 7, 0, -11, 13, 0, -19, 24, 0, -37, 48, 0,
                         -102, 206, 500, 206, -102, 0, 48, -37, 0, 24, -19, 0,
                         13, -11, 0, 7, -6, 0, 3};

    fir_filter_direct #(.TRANSPOSED(0)) dutDirect (
        .iClk_12M(clk), .iRsn(rst), .iCoeffiUpdateFlag(flag), .iCsnRam(csn),
        .iWrnRam(wrn), .iAddrRam(addr), .iWrDtRam(wdat), .iFirIn(xin),
        .oFirOut(out0)
    );

    fir_filter_direct #(.TRANSPOSED(1)) dutTransposed (
        .iClk_12M(clk), .iRsn(rst), .iCoeffiUpdateFlag(flag), .iCsnRam(csn),
        .iWrnRam(wrn), .iAddrRam(addr), .iWrDtRam(wdat), .iFirIn(xin),
        .oFirOut(out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Advances one clock. The expected output for this edge is the
    // convolution of the coefficients and history as they stood before
    // the edge.
    task automatic tick();
        int acc;
        acc = 0;
        for (int k = 0; k < 33; k++) begin
            if (k < xq.size()) acc += mH[k] * xq[k];
        end
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 33; k++) mH[k] = 0;
            xq.delete();
            mOut = 0;
        end else begin
            mOut = sat16(acc);
            xq.push_front(int'(xin));
            if (xq.size() > 33) void'(xq.pop_back());
            if (flag && !csn && !wrn && addr >= 6'd1 && addr <= 6'd33)
                mH[int'(addr) - 1] = int'(wdat);
        end
        #1;
    endtask

    task automatic bus_cycle(input logic f, input logic c, input logic w,
                             input logic [5:0] a, input logic signed [15:0] d);
        flag = f; csn = c; wrn = w; addr = a; wdat = d;
        tick();
        flag = 1'b0; csn = 1'b1; wrn = 1'b1; addr = '0; wdat = '0;
    endtask

    task automatic flush();
        xin = '0;
        for (int i = 0; i < 34; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        xin = 3'sd3;
        bus_cycle(1'b1, 1'b0, 1'b0, 6'd1, 16'sd777);
        tick();
        tests++;
        if (out0 !== 16'sd0 || out1 !== 16'sd0) begin
            fails++;
            $display("FAIL reset_out: got %0d/%0d required 0", out0, out1);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_coef();
        xin = 3'sd3;
        for (int i = 0; i < 50; i++) begin
            tick();
            tests++;
            if (out0 !== 16'sd0 || out1 !== 16'sd0) begin
                fails++;
                $display("FAIL zero_coef cyc%0d: got %0d/%0d required 0", i, out0, out1);
            end
        end
    endtask

    task automatic test_coef_write();
        xin = 3'sd1;
        for (int k = 0; k < 33; k++) begin
            bus_cycle(1'b1, 1'b0, 1'b0, 6'(k + 1), 16'(coefTab[k]));
            tests++;
            if (out0 !== 16'(mOut) || out1 !== 16'(mOut)) begin
                fails++;
                $display("FAIL coef_write k%0d: got %0d/%0d required %0d", k, out0, out1, mOut);
            end
        end
        flush();
    endtask

    task automatic test_impulse(input logic signed [2:0] amp, input string tag);
        int req;
        xin = amp;
        tick();
        xin = '0;
        for (int k = 0; k < 34; k++) begin
            tick();
            req = (k < 33) ? int'(amp) * coefTab[k] : 0;
            tests++;
            if (out0 !== 16'(req) || out1 !== 16'(req) || mOut != req) begin
                fails++;
                $display("FAIL %s k%0d: got %0d/%0d model %0d required %0d",
                         tag, k, out0, out1, mOut, req);
            end
        end
    endtask

    task automatic test_ignored_writes();
        bus_cycle(1'b0, 1'b0, 1'b0, 6'd17, 16'sd1234);
        bus_cycle(1'b1, 1'b0, 1'b1, 6'd17, 16'sd1234);
        bus_cycle(1'b1, 1'b1, 1'b0, 6'd1, 16'sd1234);
        bus_cycle(1'b1, 1'b0, 1'b0, 6'd0, 16'sd1234);
        bus_cycle(1'b1, 1'b0, 1'b0, 6'd34, 16'sd1234);
        bus_cycle(1'b1, 1'b0, 1'b0, 6'd63, 16'sd1234);
        flush();
        test_impulse(3'sd1, "ignored_writes");
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 33; k++) bus_cycle(1'b1, 1'b0, 1'b0, 6'(k + 1), 16'sh7FFF);
        flush();
        xin = 3'sd3;
        for (int i = 0; i < 40; i++) begin
            tick();
            tests++;
            if (out0 !== 16'(mOut) || out1 !== 16'(mOut)) begin
                fails++;
                $display("FAIL sat_pos cyc%0d: got %0d/%0d required %0d", i, out0, out1, mOut);
            end
        end
        tests++;
        if (out0 !== 16'sh7FFF || out1 !== 16'sh7FFF) begin
            fails++;
            $display("FAIL sat_pos_final: got %0d/%0d required 32767", out0, out1);
        end
        xin = -3'sd4;
        for (int i = 0; i < 40; i++) begin
            tick();
            tests++;
            if (out0 !== 16'(mOut) || out1 !== 16'(mOut)) begin
                fails++;
                $display("FAIL sat_neg cyc%0d: got %0d/%0d required %0d", i, out0, out1, mOut);
            end
        end
        tests++;
        if (out0 !== 16'sh8000 || out1 !== 16'sh8000) begin
            fails++;
            $display("FAIL sat_neg_final: got %0d/%0d required -32768", out0, out1);
        end
    endtask

    // Random samples with random coefficient traffic and mid-stream rewrites.
    task automatic test_random_stream();
        int sel;
        for (int i = 0; i < 400; i++) begin
            xin = 3'($urandom_range(0, 7));
            sel = int'($urandom_range(0, 9));
            flag = (sel < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            csn  = 1'($urandom_range(0, 3) == 0);
            wrn  = 1'($urandom_range(0, 3) == 0);
            addr = 6'($urandom_range(0, 40));
            wdat = (sel == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 800)) - 400);
            tick();
            tests++;
            if (out0 !== 16'(mOut) || out1 !== 16'(mOut) || out0 !== out1) begin
                fails++;
                $display("FAIL random cyc%0d: got %0d/%0d required %0d", i, out0, out1, mOut);
            end
        end
        flag = 1'b0; csn = 1'b1; wrn = 1'b1;
    endtask

    task automatic test_reset_midstream();
        for (int k = 0; k < 33; k++) bus_cycle(1'b1, 1'b0, 1'b0, 6'(k + 1), 16'(coefTab[k]));
        xin = 3'sd3;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        bus_cycle(1'b1, 1'b0, 1'b0, 6'd17, 16'sd500);
        rst = 1'b0;
        xin = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (out0 !== 16'sd0 || out1 !== 16'sd0) begin
                fails++;
                $display("FAIL reset_mid cyc%0d: got %0d/%0d required 0", i, out0, out1);
            end
        end
        // Coefficients must have been cleared, so a strong impulse yields 0.
        xin = 3'sd3;
        tick();
        xin = '0;
        for (int i = 0; i < 34; i++) begin
            tick();
            tests++;
            if (out0 !== 16'sd0 || out1 !== 16'sd0) begin
                fails++;
                $display("FAIL reset_coef_clear k%0d: got %0d/%0d required 0", i, out0, out1);
            end
        end
    endtask

    initial begin
        tests = 0; fails = 0; mOut = 0;
        for (int k = 0; k < 33; k++) mH[k] = 0;
        rst = 1'b1; flag = 1'b0; csn = 1'b1; wrn = 1'b1;
        addr = '0; wdat = '0; xin = '0;
        #2;
        test_reset();
        test_zero_coef();
        test_coef_write();
        test_impulse(3'sd1, "impulse_pos");
        test_impulse(-3'sd4, "impulse_neg");
        test_ignored_writes();
        test_saturation();
        test_random_stream();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
